mul_tile_seq: RTL and testbench
===============================

MUL_TILE_SEQ -- requirements
Module: mul_tile_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of each systolic operand lane.
REQ-002 SHALL have parameter SYSTOLIC_WIDTH, default 4: number of lanes (N); also beats per tile.
REQ-003 SHALL have parameter NARROW_WIDTH, default 8: width of each packed right-operand lane.
REQ-004 SHALL have parameter TILE_CNT_W, default 16: width of the tile counter.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, named as in the codebase: clk (input, 1, clock) and rst_n (input, 1, async active-low reset).
REQ-006 SHALL have start (input, 1): one-cycle job request.
REQ-007 SHALL have mem_mode (input, 3): 0 IDLE, 1 AS, 2 SA, 3 SB, 4 BS; sampled on an accepted start.
REQ-008 SHALL have num_tiles (input, TILE_CNT_W): tiles in the job; sampled on an accepted start.
REQ-009 SHALL have data_left (input, N*DATA_WIDTH): left operand beat.
REQ-010 SHALL have data_right (input, 2*N*NARROW_WIDTH): packed right operand beat.
REQ-011 SHALL have in_valid (input, 1) and in_ready (output, 1): beat handshake.
REQ-012 SHALL have a_in_raw and b_in_raw (outputs, N*DATA_WIDTH each): registered operands.
REQ-013 SHALL have out_valid (output, 1): a_in_raw and b_in_raw are valid.
REQ-014 SHALL have transposition_slect, systolic_mode and systolic_state (outputs, 1 each).
REQ-015 SHALL have busy (output, 1) and done (output, 1, one-cycle pulse).

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, CALC and DRAIN.
REQ-017 SHALL, in IDLE, accept start only when mem_mode is 1..4 and num_tiles is nonzero, then go to LOAD; start with mode 0 or >4 SHALL be ignored.
REQ-018 SHALL, on start with a valid mode and num_tiles==0, pulse done on the next cycle and remain in IDLE.
REQ-019 SHALL ignore start while busy.
REQ-020 SHALL, in LOAD, accept N beats, then enter CALC; CALC SHALL accept N beats per tile for num_tiles tiles, then enter DRAIN.
REQ-021 SHALL assert in_ready only in LOAD and CALC; a beat transfers when in_valid and in_ready are both high.
REQ-022 SHALL stay in DRAIN for exactly 2N-1 cycles, then return to IDLE with done pulsed on the transition cycle.
REQ-023 SHALL register outputs with a latency of 1 cycle: out_valid is high on the cycle after each transfer and low otherwise.
REQ-024 SHALL build b_in_raw by zero-extending N NARROW_WIDTH lanes to DATA_WIDTH, with lane i mapped to bits [i*DW+:DW]; it SHALL use the lower half of data_right when half_sel is 0 and the upper half when it is 1.
REQ-025 SHALL clear half_sel at job start and toggle it at each tile boundary in CALC.
REQ-026 SHALL initialise transposition_slect to 0 for AS/SB and 1 for SA/BS, and toggle it after every completed tile (ping-pong).
REQ-027 SHALL drive systolic_mode 0 (weight-stationary) for AS/SA and 1 (output-stationary) for SB/BS.
REQ-028 SHALL drive systolic_state 0 in IDLE/LOAD and 1 in CALC/DRAIN.
REQ-029 SHALL stall counters, without losing or duplicating beats, while in_valid is low.
REQ-030 SHALL drive busy high in every state except IDLE.

Reset
REQ-031 SHALL, while rst_n is low, force: FSM IDLE; all counters 0; a_in_raw, b_in_raw, out_valid, in_ready, busy, done, transposition_slect, systolic_mode and systolic_state all 0.
REQ-032 SHALL abort any job on reset mid-operation without a done pulse.

Configuration
REQ-033 SHALL, with MUL_TILE_SEQ_STALL_CNT_EN defined, add output stall_cnt (32 bits), which counts CALC cycles with in_valid low, clears at job start, saturates at all-ones and resets to 0; without the macro the port and the logic SHALL be absent.

Structure
REQ-034 SHALL place the mem_mode encoding enum and the FSM state enum in the shared package mul_pkg.
REQ-035 SHALL implement lane unpack/zero-extend in one sub-module, mul_lane_unpack.

Verification
REQ-036 SHALL cover: N=4, mode AS, num_tiles=2, continuous valid -> 4 LOAD + 8 CALC beats, transposition_slect 0,1,0, done exactly 7 cycles after the last beat.
REQ-037 SHALL cover: data_right=64'h8877665544332211, half_sel 1 -> b_in_raw=64'h0088007700660055.
REQ-038 SHALL cover: mode 5 start -> busy stays 0; mode 3 with num_tiles=0 -> done pulse next cycle, systolic_mode unchanged from reset.
REQ-039 SHALL cover: in_valid deasserted for 3 cycles mid-tile -> no beat lost, job lengthened by 3 cycles, stall_cnt=3 with the macro.
REQ-040 SHALL cover: rst_n low during CALC -> all outputs 0 immediately, no done; a new start then completes normally.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types for the tile sequencer: memory-mode encoding, FSM states and
// small decode helpers.
package mul_pkg;

  typedef enum logic [2:0] {
    MODE_IDLE = 3'd0,
    MODE_AS   = 3'd1,
    MODE_SA   = 3'd2,
    MODE_SB   = 3'd3,
    MODE_BS   = 3'd4
  } mem_mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_CALC  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  function automatic logic mode_valid(input logic [2:0] m);
    return (m >= 3'd1) && (m <= 3'd4);
  endfunction

  // SA/BS start with the transposed operand selected
  function automatic logic mode_trans_init(input mem_mode_e m);
    return (m == MODE_SA) || (m == MODE_BS);
  endfunction

  // SB/BS run output-stationary
  function automatic logic mode_out_stat(input mem_mode_e m);
    return (m == MODE_SB) || (m == MODE_BS);
  endfunction

endpackage

// File: rtl/mul_lane_unpack.sv
// Selects one half of the packed right operand and zero-extends each narrow
// lane to the systolic operand width.
module mul_lane_unpack #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 16,
  parameter int NARROW_W  = 8
) (
  input  logic [2*NUM_LANES*NARROW_W-1:0] packed_i,
  input  logic                            half_sel_i,
  output logic [NUM_LANES*DATA_W-1:0]     lanes_o
);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [NARROW_W-1:0] lane;
    assign lane = half_sel_i ? packed_i[(NUM_LANES+i)*NARROW_W +: NARROW_W]
                             : packed_i[i*NARROW_W +: NARROW_W];
    assign lanes_o[i*DATA_W +: DATA_W] = DATA_W'(lane);
  end

endmodule

// File: rtl/mul_tile_seq.sv
// Tile sequencer feeding a systolic multiplier: LOAD one tile, stream
// num_tiles tiles through CALC, then DRAIN. Optional MUL_TILE_SEQ_STALL_CNT_EN.
module mul_tile_seq
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int SYSTOLIC_WIDTH = 4,
  parameter int NARROW_WIDTH   = 8,
  parameter int TILE_CNT_W     = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [2:0]                            mem_mode,
  input  logic [TILE_CNT_W-1:0]                 num_tiles,
  input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0]  data_left,
  input  logic [2*SYSTOLIC_WIDTH*NARROW_WIDTH-1:0] data_right,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0]  a_in_raw,
  output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0]  b_in_raw,
  output logic                                  out_valid,
  output logic                                  transposition_slect,
  output logic                                  systolic_mode,
  output logic                                  systolic_state,
  output logic                                  busy,
  output logic                                  done
`ifdef MUL_TILE_SEQ_STALL_CNT_EN
 ,output logic [31:0]                           stall_cnt
`endif
);

  localparam int N  = SYSTOLIC_WIDTH;
  localparam int VW = N * DATA_WIDTH;
  localparam int CW = (2 * N > 2) ? $clog2(2 * N) : 1;
  localparam logic [CW-1:0] BEAT_LAST  = CW'(N - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(2 * N - 2);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TILE_CNT_W-1:0] tile_q, tile_d;
  logic [TILE_CNT_W-1:0] ntiles_q, ntiles_d;
  logic                  half_q, half_d;
  logic                  trans_q, trans_d;
  logic                  smode_q, smode_d;
  logic                  zdone_q, zdone_d;
  logic [VW-1:0]         a_q, b_q, b_unpacked;
  logic                  ov_q;
  logic                  xfer, start_ok, job_start;

  assign in_ready  = (state_q == S_LOAD) || (state_q == S_CALC);
  assign xfer      = in_valid && in_ready;
  assign start_ok  = (state_q == S_IDLE) && start && mode_valid(mem_mode);
  assign job_start = start_ok && (num_tiles != '0);

  mul_lane_unpack #(
    .NUM_LANES (N),
    .DATA_W    (DATA_WIDTH),
    .NARROW_W  (NARROW_WIDTH)
  ) u_unpack (
    .packed_i   (data_right),
    .half_sel_i (half_q),
    .lanes_o    (b_unpacked)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tile_d   = tile_q;
    ntiles_d = ntiles_q;
    half_d   = half_q;
    trans_d  = trans_q;
    smode_d  = smode_q;
    zdone_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // zero-tile jobs only acknowledge; mode outputs stay untouched
        if (start_ok && !job_start) zdone_d = 1'b1;
        if (job_start) begin
          state_d  = S_LOAD;
          cnt_d    = '0;
          tile_d   = '0;
          ntiles_d = num_tiles;
          half_d   = 1'b0;
          trans_d  = mode_trans_init(mem_mode_e'(mem_mode));
          smode_d  = mode_out_stat(mem_mode_e'(mem_mode));
        end
      end
      S_LOAD: begin
        if (xfer) begin
          if (cnt_q == BEAT_LAST) begin
            cnt_d   = '0;
            state_d = S_CALC;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_CALC: begin
        if (xfer) begin
          if (cnt_q == BEAT_LAST) begin
            cnt_d   = '0;
            half_d  = ~half_q;
            trans_d = ~trans_q;
            if (tile_q == ntiles_q - TILE_CNT_W'(1)) begin
              tile_d  = '0;
              state_d = S_DRAIN;
            end else begin
              tile_d = tile_q + TILE_CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tile_q   <= '0;
      ntiles_q <= '0;
      half_q   <= 1'b0;
      trans_q  <= 1'b0;
      smode_q  <= 1'b0;
      zdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tile_q   <= tile_d;
      ntiles_q <= ntiles_d;
      half_q   <= half_d;
      trans_q  <= trans_d;
      smode_q  <= smode_d;
      zdone_q  <= zdone_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      ov_q <= 1'b0;
    end else begin
      ov_q <= xfer;
      if (xfer) begin
        a_q <= data_left;
        b_q <= b_unpacked;
      end
    end
  end

`ifdef MUL_TILE_SEQ_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           stall_q <= '0;
    else if (job_start)                                   stall_q <= '0;
    else if (state_q == S_CALC && !in_valid && stall_q != '1) stall_q <= stall_q + 32'd1;
  end
  assign stall_cnt = stall_q;
`endif

  assign a_in_raw            = a_q;
  assign b_in_raw            = b_q;
  assign out_valid           = ov_q;
  assign transposition_slect = trans_q;
  assign systolic_mode       = smode_q;
  assign systolic_state      = (state_q == S_CALC) || (state_q == S_DRAIN);
  assign busy                = (state_q != S_IDLE);
  // done fires during the last DRAIN cycle, i.e. the cycle that returns to IDLE
  assign done                = zdone_q || (state_q == S_DRAIN && cnt_q == DRAIN_LAST);

endmodule

// File: tb/tb_mul_tile_seq.sv
// Scoreboard bench for mul_tile_seq: randomized jobs, reference model of the
// operand stream, directed mode/reset/stall scenarios.
module tb_mul_tile_seq;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int NW = 8;
  localparam int TW = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [2:0]            mem_mode = '0;
  logic [TW-1:0]         num_tiles = '0;
  logic [N*DW-1:0]       data_left = '0;
  logic [2*N*NW-1:0]     data_right = '0;
  logic                  in_valid = 1'b0;
  logic                  in_ready, out_valid, transposition_slect;
  logic                  systolic_mode, systolic_state, busy, done;
  logic [N*DW-1:0]       a_in_raw, b_in_raw;
`ifdef MUL_TILE_SEQ_STALL_CNT_EN
  logic [31:0]           stall_cnt;
`endif

  mul_tile_seq #(.DATA_WIDTH(DW), .SYSTOLIC_WIDTH(N), .NARROW_WIDTH(NW), .TILE_CNT_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_mode(mem_mode), .num_tiles(num_tiles),
    .data_left(data_left), .data_right(data_right), .in_valid(in_valid), .in_ready(in_ready),
    .a_in_raw(a_in_raw), .b_in_raw(b_in_raw), .out_valid(out_valid),
    .transposition_slect(transposition_slect), .systolic_mode(systolic_mode),
    .systolic_state(systolic_state), .busy(busy), .done(done)
`ifdef MUL_TILE_SEQ_STALL_CNT_EN
   ,.stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [N*DW-1:0] a; logic [N*DW-1:0] b; } exp_t;
  exp_t sb_q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pick lane half*N+i of the packed word, widen it to lane i.
  function automatic logic [N*DW-1:0] model_b(input logic [2*N*NW-1:0] dr, input int half);
    logic [N*DW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      logic [N*DW-1:0] lane;
      lane = (N*DW)'((dr >> ((half*N + i)*NW)) & ((64'd1 << NW) - 64'd1));
      r = r | (lane << (i*DW));
    end
    return r;
  endfunction

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (sb_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_out_valid: got 1 expected 0 at %0t", $time);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("a_in_raw", a_in_raw, e.a);
          chk("b_in_raw", b_in_raw, e.b);
        end
      end
    end
  end

  // smode: 0 continuous, 1 random valid + stray starts, 2 three-cycle gap mid-tile.
  // abort_at >= 0 stops issuing beats after that many and returns early.
  task automatic run_job(input int mode, input int nt, input int smode, input bit fixed_dr,
                         input int abort_at);
    int beats, k, cyc, stalls, calc_stalls, gap, d, half;
    bit tinit, os, seen;
    beats = N*(nt+1); k = 0; cyc = 0; stalls = 0; calc_stalls = 0; gap = 0;
    tinit = (mode == 2 || mode == 4);
    os    = (mode >= 3);
    @(negedge clk);
    start = 1'b1; mem_mode = 3'(mode); num_tiles = TW'(nt);
    while (k < beats && cyc < 2000 && k != abort_at) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (smode == 1 && $urandom_range(0, 7) == 0) begin
        start = 1'b1; mem_mode = 3'd1; num_tiles = TW'(1);
      end
      case (smode)
        0: in_valid = 1'b1;
        1: in_valid = ($urandom_range(0, 3) != 0);
        default: begin
          if (k == 6 && gap < 3) begin in_valid = 1'b0; gap++; end
          else in_valid = 1'b1;
        end
      endcase
      data_left  = {$urandom, $urandom};
      data_right = fixed_dr ? 64'h8877665544332211 : {$urandom, $urandom};
      if (in_ready) begin
        if (in_valid) begin
          half = (k < N) ? 0 : ((k/N - 1) % 2);
          chk("transposition_slect", transposition_slect, tinit ^ half[0]);
          chk("systolic_mode", systolic_mode, os);
          chk("systolic_state", systolic_state, k >= N);
          sb_q.push_back('{a: data_left, b: model_b(data_right, half)});
          k++;
        end else begin
          stalls++;
          if (k >= N) calc_stalls++;
        end
      end
    end
    if (k == abort_at) return;
    if (k < beats) begin
      tests++; fails++;
      $display("FAIL beat_timeout: got %0d beats expected %0d", k, beats);
    end
    d = 0; seen = 0;
    while (!seen && d < 50) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0;
      d++;
      if (done) seen = 1;
    end
    chk("done_latency", d, 2*N - 1);
    chk("job_cycles", cyc + d, beats + stalls + 2*N - 1);
    chk("trans_final", transposition_slect, tinit ^ nt[0]);
    chk("busy_at_done", busy, 1);
`ifdef MUL_TILE_SEQ_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, calc_stalls);
`endif
    @(negedge clk);
    chk("done_pulse_end", done, 0);
    chk("busy_after", busy, 0);
    chk("sb_empty", sb_q.size(), 0);
  endtask

  initial begin : stim
    #12;
    chk("rst_a", a_in_raw, 0);
    chk("rst_b", b_in_raw, 0);
    chk("rst_ctl", {out_valid, in_ready, busy, done, transposition_slect, systolic_mode, systolic_state}, 0);
    @(negedge clk); rst_n = 1'b1;

    // invalid modes are ignored
    for (int m = 0; m < 8; m += 5) begin
      @(negedge clk); start = 1'b1; mem_mode = 3'(m); num_tiles = TW'(3);
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 3; c++) begin
        chk("bad_mode_busy", busy, 0);
        chk("bad_mode_done", done, 0);
        @(negedge clk);
      end
    end

    // zero-tile job: done next cycle, stays idle, mode outputs untouched
    @(negedge clk); start = 1'b1; mem_mode = 3'd3; num_tiles = '0;
    @(negedge clk); start = 1'b0;
    chk("zero_tile_done", done, 1);
    chk("zero_tile_busy", busy, 0);
    chk("zero_tile_smode", systolic_mode, 0);
    @(negedge clk);
    chk("zero_tile_done_clr", done, 0);

    run_job(1, 2, 0, 0, -1);
    run_job(3, 3, 0, 1, -1);
    run_job(2, 2, 2, 0, -1);
    run_job(4, 3, 1, 0, -1);
    for (int j = 0; j < 6; j++)
      run_job($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(0, 2), 0, -1);

    // abort mid-CALC
    run_job(2, 3, 0, 0, N + 2);
    @(negedge clk); in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("abort_a", a_in_raw, 0);
    chk("abort_b", b_in_raw, 0);
    chk("abort_ctl", {out_valid, in_ready, busy, done, transposition_slect, systolic_mode, systolic_state}, 0);
    chk("abort_sb_empty", sb_q.size(), 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_idle", busy, 0);
    end
    run_job(1, 1, 0, 0, -1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
